spi_bus_arbiter: RTL and testbench
==================================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while instruction request pending.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles from spi_start to spi_done before abort.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  instruction fetch request; held with i_addr until i_ready.
REQ-006 i_addr  input  24  flash byte address of fetch.
REQ-007 i_ready  output  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-008 i_rdata  output  32  fetched word.
REQ-009 d_req  input  1  data request; held with d_* inputs until d_ready.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  24  RAM byte address.
REQ-012 d_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-013 d_wdata  input  32  write data, LSB-aligned.
REQ-014 d_ready  output  1  one-cycle pulse: data access complete.
REQ-015 d_rdata  output  32  read data, LSB-aligned, zero-extended; 0 on writes.
REQ-016 d_err  output  1  one-cycle pulse, coincident with i_ready or d_ready, flags timeout abort.
REQ-017 spi_start  output  1  one-cycle pulse launching one SPI transaction.
REQ-018 spi_sel  output  1  0 = flash (asserts flash chip select), 1 = RAM.
REQ-019 spi_we  output  1  transaction is a write.
REQ-020 spi_addr  output  24  transaction address.
REQ-021 spi_len  output  3  byte count 1, 2 or 4.
REQ-022 spi_wdata  output  32  write data.
REQ-023 spi_done  input  1  one-cycle pulse from SPI engine: transaction finished.
REQ-024 spi_rdata  input  32  read data, valid with spi_done.
REQ-025 spi_abort  output  1  one-cycle pulse forcing engine to idle and deassert chip selects.

Function
REQ-026 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-027 IDLE: any req sampled high -> latch winner's request fields and go to ISSUE next cycle.
REQ-028 Arbitration SHALL favour data over instruction, except instruction wins when starve_cnt == STARVE_LIMIT and i_req high.
REQ-029 starve_cnt (3+ bits, saturating) SHALL increment on each data grant while i_req high, clear on instruction grant or when i_req low in IDLE.
REQ-030 ISSUE: spi_start high exactly one cycle with latched fields stable; go to WAIT.
REQ-031 spi_sel/spi_we/spi_addr/spi_len/spi_wdata SHALL stay stable from ISSUE until return to IDLE.
REQ-032 Instruction grant: spi_sel=0, spi_we=0, spi_len=4.
REQ-033 Data grant: spi_sel=1, spi_we=d_we, spi_len=1/2/4 per d_size.
REQ-034 WAIT: spi_done -> capture spi_rdata, go to RESP; spi_done outside WAIT ignored.
REQ-035 RESP: pulse granted requester's ready one cycle with captured data; return to IDLE.
REQ-036 Minimum latency, request sampled in cycle N, spi_done in cycle M: ready in cycle M+1; next grant sampled in cycle M+2.
REQ-037 Timeout: counter starts in ISSUE; reaching TIMEOUT_CYCLES in WAIT -> spi_abort pulse, go to RESP with data 0 and d_err=1.
REQ-038 Simultaneous spi_done and timeout terminal count: spi_done wins, no error.
REQ-039 Request dropped before grant: not serviced; dropped after grant: transaction completes, ready still pulses.
REQ-040 Only one ready output SHALL pulse per transaction; never both in one cycle.
REQ-041 Read data for byte/half SHALL be spi_rdata[7:0]/[15:0] zero-extended.

Reset
REQ-042 rst_n low SHALL immediately force state IDLE, starve_cnt 0, timeout counter 0, all outputs 0.
REQ-043 Reset mid-transaction SHALL drop it with no ready pulse; spi_abort stays 0 (engine shares reset).
REQ-044 First grant possible on first rising edge after rst_n deasserts.

Verification
REQ-045 Single fetch: i_req, i_addr=0x000100; spi_done at cycle 5 with 0x00000013 -> spi_start cycle 1, sel=0, len=4, i_ready cycle 6, i_rdata=0x00000013.
REQ-046 Byte write: d_we=1, d_addr=0x000010, d_size=00, d_wdata=0xAB -> sel=1, len=1, spi_wdata=0xAB, d_ready after done, d_rdata=0.
REQ-047 Contention: both reqs held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-048 Timeout: TIMEOUT_CYCLES=16, no spi_done -> spi_abort at 16 cycles after start, d_ready with d_err=1, d_rdata=0.
REQ-049 Half read: spi_rdata=0xDEADBEEF, d_size=01 -> d_rdata=0x0000BEEF.
REQ-050 Reset in WAIT: rst_n low 2 cycles -> outputs 0, no ready pulse; pending i_req granted on first edge after release.

Source files
------------

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if
// Bundles the three sides of the SPI bus arbiter: the instruction fetch port
// (i_*), the data access port (d_*) and the SPI engine command/response
// port (spi_*).
//   master : the arbiter's view (takes requests, drives readies and engine commands)
//   slave  : the environment's view (CPU ports plus the SPI engine)
interface spi_bus_arbiter_if;
   // instruction fetch port
   logic        i_req;
   logic [23:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   // data access port
   logic        d_req;
   logic        d_we;
   logic [23:0] d_addr;
   logic [1:0]  d_size;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_err;
   // SPI engine port
   logic        spi_start;
   logic        spi_sel;
   logic        spi_we;
   logic [23:0] spi_addr;
   logic [2:0]  spi_len;
   logic [31:0] spi_wdata;
   logic        spi_done;
   logic [31:0] spi_rdata;
   logic        spi_abort;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_size, d_wdata, spi_done, spi_rdata,
      output i_ready, i_rdata, d_ready, d_rdata, d_err,
             spi_start, spi_sel, spi_we, spi_addr, spi_len, spi_wdata, spi_abort
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_size, d_wdata, spi_done, spi_rdata,
      input  i_ready, i_rdata, d_ready, d_rdata, d_err,
             spi_start, spi_sel, spi_we, spi_addr, spi_len, spi_wdata, spi_abort
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Shares one SPI engine between an instruction fetch port (flash, spi_sel=0)
// and a data port (RAM, spi_sel=1). Data normally wins; after STARVE_LIMIT
// consecutive data grants with a fetch waiting, the fetch wins once.
// A transaction that sees no spi_done within TIMEOUT_CYCLES of spi_start is
// aborted and completes with zero data and d_err.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spi_bus_arbiter_if.master (i_*, d_*, spi_* signals)
module spi_bus_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_bus_arbiter_if.master    bus
);

   localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
   localparam int SW     = (SW_RAW < 3) ? 3 : SW_RAW;
   localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_reg, state_next;
   logic          sel_reg, sel_next;
   logic          we_reg, we_next;
   logic [23:0]   addr_reg, addr_next;
   logic [2:0]    len_reg, len_next;
   logic [31:0]   wdata_reg, wdata_next;
   logic [31:0]   rdata_reg, rdata_next;
   logic          err_reg, err_next;
   logic [SW-1:0] starve_reg, starve_next;
   logic [TW-1:0] tmo_reg, tmo_next;
   logic          abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         sel_reg    <= 1'b0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         len_reg    <= '0;
         wdata_reg  <= '0;
         rdata_reg  <= '0;
         err_reg    <= 1'b0;
         starve_reg <= '0;
         tmo_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         sel_reg    <= sel_next;
         we_reg     <= we_next;
         addr_reg   <= addr_next;
         len_reg    <= len_next;
         wdata_reg  <= wdata_next;
         rdata_reg  <= rdata_next;
         err_reg    <= err_next;
         starve_reg <= starve_next;
         tmo_reg    <= tmo_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      sel_next    = sel_reg;
      we_next     = we_reg;
      addr_next   = addr_reg;
      len_next    = len_reg;
      wdata_next  = wdata_reg;
      rdata_next  = rdata_reg;
      err_next    = err_reg;
      starve_next = starve_reg;
      tmo_next    = tmo_reg;
      abort       = 1'b0;

      case (state_reg)
         IDLE: begin
            tmo_next = '0;
            err_next = 1'b0;
            // no fetch waiting: nothing is being starved
            if (!bus.i_req)
               starve_next = '0;
            if (bus.i_req && (starve_reg == SW'(STARVE_LIMIT) || !bus.d_req)) begin
               state_next  = ISSUE;
               sel_next    = 1'b0;
               we_next     = 1'b0;
               addr_next   = bus.i_addr;
               len_next    = 3'd4;
               wdata_next  = '0;
               starve_next = '0;
            end else if (bus.d_req) begin
               state_next = ISSUE;
               sel_next   = 1'b1;
               we_next    = bus.d_we;
               addr_next  = bus.d_addr;
               wdata_next = bus.d_wdata;
               case (bus.d_size)
                  2'b00:   len_next = 3'd1;
                  2'b01:   len_next = 3'd2;
                  default: len_next = 3'd4;
               endcase
               // fetch waiting and losing: count towards the starvation limit
               if (bus.i_req && starve_reg != SW'(STARVE_LIMIT))
                  starve_next = starve_reg + SW'(1);
            end
         end
         ISSUE: begin
            tmo_next   = tmo_reg + TW'(1);
            state_next = WAIT;
         end
         WAIT: begin
            // spi_done beats a timeout landing in the same cycle
            if (bus.spi_done) begin
               state_next = RESP;
               if (we_reg)
                  rdata_next = '0;
               else begin
                  case (len_reg)
                     3'd1:    rdata_next = {24'd0, bus.spi_rdata[7:0]};
                     3'd2:    rdata_next = {16'd0, bus.spi_rdata[15:0]};
                     default: rdata_next = bus.spi_rdata;
                  endcase
               end
            end else if (tmo_reg == TW'(TIMEOUT_CYCLES)) begin
               abort      = 1'b1;
               state_next = RESP;
               rdata_next = '0;
               err_next   = 1'b1;
            end else begin
               tmo_next = tmo_reg + TW'(1);
            end
         end
         RESP: begin
            tmo_next   = '0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.spi_start = (state_reg == ISSUE);
   assign bus.spi_sel   = sel_reg;
   assign bus.spi_we    = we_reg;
   assign bus.spi_addr  = addr_reg;
   assign bus.spi_len   = len_reg;
   assign bus.spi_wdata = wdata_reg;
   assign bus.spi_abort = abort;

   // read data is only presented alongside its ready pulse
   assign bus.i_ready = (state_reg == RESP) && !sel_reg;
   assign bus.d_ready = (state_reg == RESP) && sel_reg;
   assign bus.i_rdata = bus.i_ready ? rdata_reg : 32'd0;
   assign bus.d_rdata = bus.d_ready ? rdata_reg : 32'd0;
   assign bus.d_err   = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_bus_arbiter_if bus();

   spi_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        is_d;
      logic        we;
      logic [23:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [31:0] rd;
      int          delay;
      logic [2:0]  e_len;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // steps until spi_start is seen, returns cycles taken (20 = never)
   task automatic wait_start(output int n);
      n = 0;
      while (!bus.spi_start && n < 20) begin
         step();
         n++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      if (v.is_d) begin
         bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
         bus.d_size = v.size; bus.d_wdata = v.wdata;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = v.addr;
      end
      wait_start(n);
      chk("start_lat", n, 1);
      chk("sel", {31'd0, bus.spi_sel}, {31'd0, v.is_d});
      chk("we", {31'd0, bus.spi_we}, {31'd0, v.we});
      chk("addr", {8'd0, bus.spi_addr}, {8'd0, v.addr});
      chk("len", {29'd0, bus.spi_len}, {29'd0, v.e_len});
      if (v.is_d && v.we) chk("wdata", bus.spi_wdata, v.wdata);
      step();
      chk("start_pulse", {31'd0, bus.spi_start}, 32'd0);
      for (int k = 1; k < v.delay; k++) step();
      bus.spi_done = 1'b1; bus.spi_rdata = v.rd;
      step();
      bus.spi_done = 1'b0; bus.spi_rdata = 32'd0;
      chk("ready", {31'd0, v.is_d ? bus.d_ready : bus.i_ready}, 32'd1);
      chk("other_ready", {31'd0, v.is_d ? bus.i_ready : bus.d_ready}, 32'd0);
      chk("rdata", v.is_d ? bus.d_rdata : bus.i_rdata, v.e_rdata);
      chk("err", {31'd0, bus.d_err}, 32'd0);
      chk("sel_stable", {31'd0, bus.spi_sel}, {31'd0, v.is_d});
      $display("vec %0d: %s addr=0x%06h len=%0d rdata=0x%08h", idx,
               v.is_d ? "data" : "fetch", bus.spi_addr, bus.spi_len,
               v.is_d ? bus.d_rdata : bus.i_rdata);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      step();
      chk("ready_gone", {30'd0, bus.i_ready, bus.d_ready}, 32'd0);
   endtask

   initial begin : main
      int n;
      int c;
      logic [9:0] exp_sel;

      //               is_d we addr       size   wdata         rd            dly len  e_rdata
      vecs[0] = '{1'b0, 1'b0, 24'h000100, 2'b00, 32'h0,        32'h00000013, 4, 3'd4, 32'h00000013};
      vecs[1] = '{1'b1, 1'b1, 24'h000010, 2'b00, 32'h000000AB, 32'hFFFFFFFF, 3, 3'd1, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 24'h000020, 2'b01, 32'h0,        32'hDEADBEEF, 2, 3'd2, 32'h0000BEEF};
      vecs[3] = '{1'b1, 1'b0, 24'h000021, 2'b00, 32'h0,        32'hDEADBEEF, 1, 3'd1, 32'h000000EF};
      vecs[4] = '{1'b1, 1'b0, 24'h000024, 2'b10, 32'h0,        32'h12345678, 5, 3'd4, 32'h12345678};
      vecs[5] = '{1'b1, 1'b0, 24'h000028, 2'b11, 32'h0,        32'hCAFEF00D, 2, 3'd4, 32'hCAFEF00D};
      vecs[6] = '{1'b1, 1'b1, 24'h00002C, 2'b01, 32'h00001234, 32'h55555555, 3, 3'd2, 32'h0};
      vecs[7] = '{1'b0, 1'b0, 24'hFFFFFC, 2'b00, 32'h0,        32'hA5A5A5A5, 1, 3'd4, 32'hA5A5A5A5};

      bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
      bus.d_size = 0; bus.d_wdata = 0; bus.spi_done = 0; bus.spi_rdata = 0;

      // reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_start", {31'd0, bus.spi_start}, 32'd0);
      chk("rst_ready", {30'd0, bus.i_ready, bus.d_ready}, 32'd0);
      chk("rst_len", {29'd0, bus.spi_len}, 32'd0);
      chk("rst_abort", {31'd0, bus.spi_abort}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // spi_done while idle is ignored
      bus.spi_done = 1'b1; bus.spi_rdata = 32'h77777777;
      step();
      bus.spi_done = 1'b0; bus.spi_rdata = 32'd0;
      chk("idle_done_ready", {30'd0, bus.i_ready, bus.d_ready}, 32'd0);
      step();
      chk("idle_done_ready2", {30'd0, bus.i_ready, bus.d_ready}, 32'd0);
      $display("idle spi_done ignored");

      // contention: both held, grant order D,D,D,D,I,D,D,D,D,I
      exp_sel = 10'b0111101111;  // bit g = expected spi_sel of grant g
      bus.i_req = 1'b1; bus.i_addr = 24'h000400;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 24'h000080; bus.d_size = 2'b10;
      for (int g = 0; g < 10; g++) begin
         wait_start(n);
         chk(g == 0 ? "cont_lat" : "regrant_lat", n, g == 0 ? 1 : 2);
         chk("cont_sel", {31'd0, bus.spi_sel}, {31'd0, exp_sel[g]});
         step();
         bus.spi_done = 1'b1; bus.spi_rdata = 32'h0000_1000 + g;
         step();
         bus.spi_done = 1'b0;
         chk("cont_ready", {30'd0, bus.i_ready, bus.d_ready},
             exp_sel[g] ? 32'd1 : 32'd2);
         $display("contention grant %0d: %s", g, bus.spi_sel ? "D" : "I");
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      step(); step();

      // timeout: no spi_done
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 24'h000040; bus.d_size = 2'b10;
      wait_start(n);
      chk("tmo_start_lat", n, 1);
      c = 0;
      while (!bus.spi_abort && c < 40) begin
         step();
         c++;
      end
      chk("abort_cycle", c, 16);
      chk("abort_no_ready", {31'd0, bus.d_ready}, 32'd0);
      step();
      chk("tmo_ready", {31'd0, bus.d_ready}, 32'd1);
      chk("tmo_err", {31'd0, bus.d_err}, 32'd1);
      chk("tmo_rdata", bus.d_rdata, 32'd0);
      chk("tmo_abort_pulse", {31'd0, bus.spi_abort}, 32'd0);
      bus.d_req = 1'b0;
      $display("timeout abort after %0d cycles", c);
      step();
      chk("tmo_err_gone", {31'd0, bus.d_err}, 32'd0);

      // spi_done on the terminal count wins
      bus.d_req = 1'b1;
      wait_start(n);
      repeat (16) step();
      bus.spi_done = 1'b1; bus.spi_rdata = 32'h11223344;
      #1;
      chk("tc_no_abort", {31'd0, bus.spi_abort}, 32'd0);
      step();
      bus.spi_done = 1'b0;
      chk("tc_ready", {31'd0, bus.d_ready}, 32'd1);
      chk("tc_err", {31'd0, bus.d_err}, 32'd0);
      chk("tc_rdata", bus.d_rdata, 32'h11223344);
      bus.d_req = 1'b0;
      $display("done on terminal count completed normally");
      step();

      // request dropped after grant still completes
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b00; bus.d_wdata = 32'h5A;
      wait_start(n);
      bus.d_req = 1'b0;
      step(); step();
      bus.spi_done = 1'b1;
      step();
      bus.spi_done = 1'b0;
      chk("drop_ready", {31'd0, bus.d_ready}, 32'd1);
      step();
      step();
      chk("drop_no_regrant", {31'd0, bus.spi_start}, 32'd0);
      $display("dropped-after-grant request completed");

      // reset while in WAIT, pending fetch granted after release
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10;
      wait_start(n);
      step();
      bus.i_req = 1'b1; bus.i_addr = 24'h000200; bus.d_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstw_sel", {31'd0, bus.spi_sel}, 32'd0);
      chk("rstw_addr", {8'd0, bus.spi_addr}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         step();
         chk("rstw_no_ready", {30'd0, bus.i_ready, bus.d_ready}, 32'd0);
      end
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("rstw_start", {31'd0, bus.spi_start}, 32'd1);
      chk("rstw_fetch_sel", {31'd0, bus.spi_sel}, 32'd0);
      chk("rstw_fetch_addr", {8'd0, bus.spi_addr}, 32'h200);
      step();
      bus.spi_done = 1'b1; bus.spi_rdata = 32'h0BADF00D;
      step();
      bus.spi_done = 1'b0;
      chk("rstw_iready", {31'd0, bus.i_ready}, 32'd1);
      chk("rstw_irdata", bus.i_rdata, 32'h0BADF00D);
      bus.i_req = 1'b0;
      $display("reset in WAIT dropped transaction, fetch granted after release");
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
